spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
//  SPI target (slave) peripheral. An external SPI host clocks bytes in and out of the SoC.
//  Sits on the CPU valid/ready IO bus beside the SPI master, as its protocol counterpart.
//  TX and RX byte FIFOs decouple the asynchronous SPI pins from the CPU.
//  irq is high while RX data is pending; connected to the CLINT/PLIC input.
// PARAMETERS
//  FIFO_DEPTH  4      entries per TX and RX FIFO; power of 2, >=2
//  CPOL        1'b1   SCLK idle level. CPHA=1 fixed: drive on leading edge, sample on trailing
//  FILL_BYTE   8'hFF  byte shifted out on MISO when the TX FIFO is empty at byte start
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous, active-low reset
//  valid        in   1   bus request; caller holds it until ready, gates it with !ready
//  ready        out  1   one-cycle completion pulse
//  ctrl         in   1   register select: 0=DATA, 1=STATUS (cpu_mem_addr[2])
//  wstrb        in   4   byte write strobes; 0 = read
//  wdata        in   32  write data
//  rdata        out  32  read data; valid while ready=1, else 0
//  irq          out  1   = !rx_empty (registered)
//  spi_cen_i    in   1   host chip select, active low, async
//  spi_sclk_i   in   1   host SCLK, async
//  spi_mosi_i   in   1   host->target data, async
//  spi_miso_o   out  1   target->host data
//  spi_miso_oe  out  1   MISO output enable = synced cs active
// BEHAVIOUR
//  Reset: ready=0, rdata=0, irq=0, miso_o=1, miso_oe=0, FIFOs empty, stickies 0, bit_cnt=0.
//  Sync: cen, sclk and mosi each pass through a 2-FF synchronizer plus an edge register.
//   Pin edge to internal event = 3 clk. Requires f_clk >= 8*f_sclk.
//  Arming: cen sync flops reset to 0. A frame starts only on a synced falling edge of cen
//   that follows >=1 synced-high cycle after reset. A host mid-frame at reset is ignored.
//  Frame start (cen falling): bit_cnt=0. Leading edges before cen falls are ignored.
//  Leading SCLK edge (CPOL=1: falling), cen low:
//   - bit_cnt==0: load tx_sh from TX head and pop; load FILL_BYTE if TX is empty.
//   - otherwise: tx_sh <<= 1.
//   - miso_o = tx_sh[7], MSB first, updated within 4 clk of the pin edge.
//  Trailing edge: rx_sh = {rx_sh[6:0], mosi}; bit_cnt++ (3-bit, wraps).
//   On the 8th trailing edge, push the byte to RX.
//   If RX is full, drop the byte and set rx_ovf.
//  cen rising mid-byte: discard the partial byte, bit_cnt=0, miso_oe=0, miso_o=1. No push or pop.
//  Bus access: ready=1 on the cycle after valid is sampled with ready=0. Every access completes.
//   - DATA read: rdata = {!rx_empty, 23'b0, rx_head}, then pop. Empty -> 32'h0, no pop.
//   - DATA write with wstrb[0]: push wdata[7:0] to TX. If TX is full, drop and set tx_ovf.
//     wstrb==4'b0 or wstrb[0]=0 with a write -> no effect.
//   - STATUS read: {25'b0, rx_ovf, tx_ovf, tx_full, tx_empty, rx_full, rx_empty, frame_active}.
//   - STATUS write with wstrb[0]: W1C on wdata[6]=rx_ovf and wdata[5]=tx_ovf.
//  Simultaneous events:
//   - CPU push + SPI pop on a full TX FIFO: both succeed, count unchanged.
//   - SPI push + CPU pop on a full RX FIFO: both succeed, no overflow.
//   - Sticky set + W1C in the same cycle: the set wins.
//  FIFOs use binary pointers, log2(DEPTH)+1 bits wide. full when MSBs differ and rest equal.
//   Pointers wrap naturally.
//  Status flags and irq reflect FIFO state one cycle after any push or pop.
// TESTING
//  1. Reset, then STATUS read -> rdata=32'h0000_000A (tx_empty, rx_empty); irq=0; miso_oe=0.
//  2. CPU writes DATA 0xA5. Host (mode 3, f_sclk=clk/8) sends 0x3C.
//     -> host receives 0xA5; irq rises; DATA read = 32'h8000_003C; irq falls.
//  3. TX empty, host clocks 2 bytes -> MISO = 0xFF,0xFF; RX holds both bytes in order.
//  4. Host sends FIFO_DEPTH+1 bytes with no CPU reads -> first 4 kept, 5th dropped.
//     rx_ovf=1; W1C 0x40 clears it.
//  5. cen deasserted after 5 bits -> no RX push, TX head already popped.
//     Next frame starts with bit 7 of the next TX byte.
//  6. rst_n asserted mid-frame with cen held low -> outputs at reset values.
//     No frame is accepted until cen goes high then low again.

Source files
------------

// File: rtl/spi_target.sv
// spi_target: SPI target, CPHA=1, with TX/RX byte FIFOs on the
// CPU valid/ready IO bus; irq stays high while RX data is pending.
module spi_target #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic       CPOL       = 1'b1,
  parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  output logic        ready,
  input  logic        ctrl,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        spi_cen_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]  cen_r;
  logic [2:0]  sclk_r;
  logic [2:0]  mosi_r;
  logic        frame_active;
  logic [2:0]  bit_cnt;
  logic [6:0]  tx_sh;
  logic [6:0]  rx_sh;
  logic        rx_ovf;
  logic        tx_ovf;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp;
  logic [AW:0] tx_rp;
  logic [AW:0] rx_wp;
  logic [AW:0] rx_rp;
  logic [AW:0] rx_wp_n;
  logic [AW:0] rx_rp_n;

  logic cen_fall;
  logic cen_rise;
  logic sclk_fall;
  logic sclk_rise;
  logic lead;
  logic trail;
  logic quiet;
  logic spi_lead;
  logic spi_trail;
  logic mosi_bit;

  logic tx_empty;
  logic tx_full;
  logic rx_empty;
  logic rx_full;
  logic [7:0] tx_head;
  logic [7:0] tx_byte;
  logic [7:0] rx_head;
  logic [7:0] rx_byte;

  logic tx_pop;
  logic tx_push_req;
  logic tx_push;
  logic rx_pop;
  logic rx_push_req;
  logic rx_push;

  logic        acc;
  logic        is_rd;
  logic        clr_rx;
  logic        clr_tx;
  logic [31:0] status;
  logic [31:0] rx_word;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  // pin synchronizers: [0],[1] sync stages, [2] edge register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cen_r  <= 3'b000;
      sclk_r <= {3{CPOL}};
      mosi_r <= 3'b000;
    end else begin
      cen_r  <= {cen_r[1:0], spi_cen_i};
      sclk_r <= {sclk_r[1:0], spi_sclk_i};
      mosi_r <= {mosi_r[1:0], spi_mosi_i};
    end
  end

  assign cen_fall  = cen_r[2] & ~cen_r[1];
  assign cen_rise  = ~cen_r[2] & cen_r[1];
  assign sclk_fall = sclk_r[2] & ~sclk_r[1];
  assign sclk_rise = ~sclk_r[2] & sclk_r[1];
  assign lead      = CPOL ? sclk_fall : sclk_rise;
  assign trail     = CPOL ? sclk_rise : sclk_fall;
  assign mosi_bit  = mosi_r[2];

  assign quiet     = frame_active & ~cen_rise & ~cen_fall;
  assign spi_lead  = lead & quiet;
  assign spi_trail = trail & quiet;

  assign tx_empty = tx_wp == tx_rp;
  assign rx_empty = rx_wp == rx_rp;
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];
  assign tx_byte  = tx_empty ? FILL_BYTE : tx_head;
  assign rx_byte  = {rx_sh, mosi_bit};

  assign acc   = valid & ~ready;
  assign is_rd = wstrb == 4'b0000;

  assign tx_pop      = spi_lead && (bit_cnt == 3'd0) && !tx_empty;
  assign tx_push_req = acc && !ctrl && wstrb[0];
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = acc && !ctrl && is_rd && !rx_empty;
  assign rx_push_req = spi_trail && (bit_cnt == 3'd7);
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  assign clr_rx = acc && ctrl && wstrb[0] && wdata[6];
  assign clr_tx = acc && ctrl && wstrb[0] && wdata[5];

  assign rx_wp_n = rx_wp + (AW+1)'(rx_push);
  assign rx_rp_n = rx_rp + (AW+1)'(rx_pop);

  assign status  = {25'b0, rx_ovf, tx_ovf, tx_full, tx_empty,
                    rx_full, rx_empty, frame_active};
  assign rx_word = rx_empty ? 32'h0 : {1'b1, 23'b0, rx_head};
  assign rd_val  = ctrl ? status : rx_word;

  // frame tracking and the MISO/MOSI shift registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_active <= 1'b0;
      bit_cnt      <= 3'd0;
      tx_sh        <= 7'd0;
      rx_sh        <= 7'd0;
      spi_miso_o   <= 1'b1;
      spi_miso_oe  <= 1'b0;
    end else begin
      unique case (1'b1)
        cen_rise: begin
          frame_active <= 1'b0;
          bit_cnt      <= 3'd0;
          spi_miso_oe  <= 1'b0;
          spi_miso_o   <= 1'b1;
        end
        cen_fall: begin
          frame_active <= 1'b1;
          bit_cnt      <= 3'd0;
          spi_miso_oe  <= 1'b1;
        end
        spi_lead: begin
          if (bit_cnt == 3'd0) begin
            tx_sh      <= tx_byte[6:0];
            spi_miso_o <= tx_byte[7];
          end else begin
            tx_sh      <= {tx_sh[5:0], 1'b0};
            spi_miso_o <= tx_sh[6];
          end
        end
        spi_trail: begin
          rx_sh   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers; push/pop may coincide on a full FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      tx_wp <= tx_wp + (AW+1)'(tx_push);
      tx_rp <= tx_rp + (AW+1)'(tx_pop);
      rx_wp <= rx_wp_n;
      rx_rp <= rx_rp_n;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_byte;
  end

  // overflow stickies; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      rx_ovf <= (rx_push_req && !rx_push) ||
                (rx_ovf && !clr_rx);
      tx_ovf <= (tx_push_req && !tx_push) ||
                (tx_ovf && !clr_tx);
    end
  end

  // bus response, one cycle after the access, and irq
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready <= 1'b0;
      rdata <= 32'h0;
      irq   <= 1'b0;
    end else begin
      ready <= acc;
      rdata <= (acc && is_rd) ? rd_val : 32'h0;
      irq   <= rx_wp_n != rx_rp_n;
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized scoreboard bench for spi_target
// against a queue-based model of the FIFOs and SPI host.
module tb_spi_target;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        ctrl = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;
  logic        cen = 1'b1;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  mexp_q[$];
  logic [7:0]  mgot_q[$];

  logic [7:0]  tx_m[$];
  logic [7:0]  rx_m[$];
  bit          rx_ovf_m = 1'b0;
  bit          tx_ovf_m = 1'b0;

  spi_target #(
    .FIFO_DEPTH(DEPTH),
    .CPOL(1'b1),
    .FILL_BYTE(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid(valid),
    .ready(ready),
    .ctrl(ctrl),
    .wstrb(wstrb),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq),
    .spi_cen_i(cen),
    .spi_sclk_i(sclk),
    .spi_mosi_i(mosi),
    .spi_miso_o(miso),
    .spi_miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  // bus monitor: every ready pulse consumes one expectation
  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_extra: got %h expected none", rdata);
      end else begin
        chk("bus_rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // SPI monitor: every byte the host collected is checked
  always @(posedge clk) begin
    if (mgot_q.size() > 0) begin
      if (mexp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_extra: got %h expected none",
                 mgot_q.pop_front());
      end else begin
        chk("miso_byte", mgot_q.pop_front(), mexp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] st_exp(input bit fa);
    return {25'b0, rx_ovf_m, tx_ovf_m,
            tx_m.size() == DEPTH, tx_m.size() == 0,
            rx_m.size() == DEPTH, rx_m.size() == 0, fa};
  endfunction

  task automatic bus(input logic c, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] e);
    int n;
    n = 0;
    @(negedge clk);
    valid = 1'b1;
    ctrl  = c;
    wstrb = s;
    wdata = d;
    exp_q.push_back(e);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 10);
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: got no ready expected ready");
      void'(exp_q.pop_back());
    end
    valid = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] b, input logic [3:0] s);
    logic [31:0] d;
    d = $urandom;
    d[7:0] = b;
    if (s[0]) begin
      if (tx_m.size() < DEPTH) tx_m.push_back(b);
      else tx_ovf_m = 1'b1;
    end
    bus(1'b0, s, d, 32'h0);
  endtask

  task automatic cpu_rd();
    logic [31:0] e;
    e = 32'h0;
    if (rx_m.size() > 0) e = {1'b1, 23'b0, rx_m.pop_front()};
    bus(1'b0, 4'h0, $urandom, e);
  endtask

  task automatic st_rd(input bit fa);
    bus(1'b1, 4'h0, $urandom, st_exp(fa));
  endtask

  task automatic st_w1c(input logic [3:0] s, input logic [31:0] d);
    if (s[0]) begin
      if (d[6]) rx_ovf_m = 1'b0;
      if (d[5]) tx_ovf_m = 1'b0;
    end
    bus(1'b1, s, d, 32'h0);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cen = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cen = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // mode 3 host byte, sclk = clk/8; live=0 means target unarmed
  task automatic host_byte(input logic [7:0] mo, input int nb,
                           input bit live);
    logic [7:0] got;
    logic [7:0] tb;
    got = 8'h0;
    tb  = 8'hFF;
    if (live && tx_m.size() > 0) tb = tx_m.pop_front();
    mexp_q.push_back(tb >> (8 - nb));
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      mosi = mo[7-i];
      repeat (4) @(negedge clk);
      got  = {got[6:0], miso};
      sclk = 1'b1;
      repeat (3) @(negedge clk);
    end
    mgot_q.push_back(got);
    if (live && nb == 8) begin
      if (rx_m.size() < DEPTH) rx_m.push_back(mo);
      else rx_ovf_m = 1'b1;
    end
  endtask

  task automatic model_reset();
    tx_m.delete();
    rx_m.delete();
    rx_ovf_m = 1'b0;
    tx_ovf_m = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_irq", irq, 1'b0);
    chk("reset_oe", miso_oe, 1'b0);
    chk("reset_miso", miso, 1'b1);
    chk("reset_rdata", rdata, 32'h0);
    st_rd(1'b0);

    // one byte each way
    cpu_wr(8'hA5, 4'h1);
    cs_low();
    chk("oe_active", miso_oe, 1'b1);
    st_rd(1'b1);
    host_byte(8'h3C, 8, 1'b1);
    cs_high();
    chk("oe_idle", miso_oe, 1'b0);
    chk("irq_rise", irq, 1'b1);
    cpu_rd();
    chk("irq_fall", irq, 1'b0);

    // empty TX sends fill bytes
    cs_low();
    host_byte(8'h11, 8, 1'b1);
    host_byte(8'h22, 8, 1'b1);
    cs_high();
    cpu_rd();
    cpu_rd();
    cpu_rd();

    // RX overflow and W1C
    cs_low();
    for (int i = 0; i < DEPTH + 1; i++)
      host_byte(8'h40 + 8'(i), 8, 1'b1);
    cs_high();
    st_rd(1'b0);
    st_w1c(4'h1, 32'h40);
    st_rd(1'b0);
    for (int i = 0; i < DEPTH; i++) cpu_rd();
    st_rd(1'b0);

    // TX overflow, write without wstrb[0]
    for (int i = 0; i < DEPTH + 1; i++) cpu_wr(8'h80 + 8'(i), 4'h1);
    cpu_wr(8'h55, 4'h2);
    st_rd(1'b0);
    st_w1c(4'h1, 32'h20);
    cs_low();
    for (int i = 0; i < DEPTH; i++) host_byte(8'h00, 8, 1'b1);
    cs_high();
    for (int i = 0; i < DEPTH; i++) cpu_rd();

    // partial byte: TX head popped, nothing pushed
    cpu_wr(8'h96, 4'h1);
    cpu_wr(8'h5A, 4'h1);
    cs_low();
    host_byte(8'hC3, 5, 1'b1);
    cs_high();
    st_rd(1'b0);
    cs_low();
    host_byte(8'h77, 8, 1'b1);
    cs_high();
    cpu_rd();

    // reset mid-frame with cen held low
    cpu_wr(8'hE1, 4'h1);
    cs_low();
    host_byte(8'h81, 3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_mid_oe", miso_oe, 1'b0);
    chk("rst_mid_miso", miso, 1'b1);
    chk("rst_mid_irq", irq, 1'b0);
    st_rd(1'b0);
    host_byte(8'h42, 8, 1'b0);
    repeat (8) @(negedge clk);
    st_rd(1'b0);
    cs_high();
    cs_low();
    host_byte(8'h42, 8, 1'b1);
    cs_high();
    cpu_rd();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: cpu_wr(8'($urandom), 4'($urandom_range(1, 15)));
        1: cpu_rd();
        2: st_rd(1'b0);
        3: st_w1c(4'($urandom_range(1, 15)), $urandom);
        default: begin
          int nb;
          nb = $urandom_range(1, 3);
          cs_low();
          for (int k = 0; k < nb; k++)
            host_byte(8'($urandom), 8, 1'b1);
          cs_high();
        end
      endcase
      @(negedge clk);
      chk("rand_irq", irq, rx_m.size() != 0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drain", exp_q.size() + mexp_q.size() + mgot_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
